// File: rtl/qam_symbol_mapper_if.sv
// Stream bundle between the serial-bit source, the constellation mapper and the IFFT loader.
// The master side feeds bits and accepts symbols; the slave side is the mapper itself.
interface qam_symbol_mapper_if #(
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
);
    logic [1:0]              mode;
    logic                    bit_in;
    logic                    bit_valid;
    logic                    bit_ready;
    logic signed [OUT_W-1:0] sym_i;
    logic signed [OUT_W-1:0] sym_q;
    logic                    sym_valid;
    logic                    sym_ready;
    logic [CNT_W-1:0]        sym_count;
    logic                    mode_err;

    modport master (
        output mode, bit_in, bit_valid, sym_ready,
        input  bit_ready, sym_i, sym_q, sym_valid, sym_count, mode_err
    );

    modport slave (
        input  mode, bit_in, bit_valid, sym_ready,
        output bit_ready, sym_i, sym_q, sym_valid, sym_count, mode_err
    );
endinterface

// File: rtl/qam_symbol_mapper.sv
// Serial-bit to BPSK/QPSK/16-QAM constellation mapper with a one-deep output register,
// valid/ready backpressure on both sides and a wrapping count of delivered symbols.
module qam_symbol_mapper #(
    parameter int OUT_W = 8,
    parameter int AMP   = 24,
    parameter int CNT_W = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    qam_symbol_mapper_if.slave   bus
);

    if (3 * AMP > (2 ** (OUT_W - 1)) - 1) begin : g_amp_check
        $error("qam_symbol_mapper: 3*AMP does not fit in signed OUT_W");
    end

    localparam logic signed [OUT_W-1:0] LVL1 = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] LVL3 = OUT_W'(3 * AMP);

    typedef enum logic {COLLECT, LAST} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              bit_cnt_q, bit_cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic [2:0]              sh_q, sh_d;
    logic signed [OUT_W-1:0] sym_i_q, sym_i_d;
    logic signed [OUT_W-1:0] sym_q_q, sym_q_d;
    logic                    sym_valid_q, sym_valid_d;
    logic [CNT_W-1:0]        sym_count_q, sym_count_d;
    logic                    mode_err_q, mode_err_d;

    logic [1:0] eff_mode;
    logic [1:0] last_idx;
    logic [3:0] bits_full;
    logic       final_bit;
    logic       ready;
    logic       accept;
    logic       drain;

    // One Gray-coded axis: BPSK/QPSK use only msb, 16-QAM uses {msb,lsb}.
    function automatic logic signed [OUT_W-1:0] axis_level(input logic msb, input logic lsb,
                                                           input logic qam);
        if (!qam) begin
            return msb ? LVL1 : -LVL1;
        end
        case ({msb, lsb})
            2'b00:   return -LVL3;
            2'b01:   return -LVL1;
            2'b11:   return LVL1;
            default: return LVL3;
        endcase
    endfunction

    always_comb begin
        // The mode input only matters on b0; afterwards the latched copy rules.
        eff_mode = (bit_cnt_q == 2'd0) ? bus.mode : mode_q;
        case (eff_mode)
            2'b00:   last_idx = 2'd0;
            2'b10:   last_idx = 2'd3;
            default: last_idx = 2'd1;
        endcase
        final_bit = (state_q == LAST) || (bit_cnt_q == 2'd0 && last_idx == 2'd0);
        drain     = sym_valid_q & bus.sym_ready;
        ready     = RESET_N & ~(final_bit & sym_valid_q & ~bus.sym_ready);
        accept    = bus.bit_valid & ready;
        bits_full = {1'b0, sh_q};
        bits_full[bit_cnt_q] = bus.bit_in;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        mode_d      = mode_q;
        sh_d        = sh_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        sym_valid_d = sym_valid_q;
        sym_count_d = sym_count_q;
        mode_err_d  = mode_err_q;

        if (drain) begin
            sym_count_d = sym_count_q + CNT_W'(1);
            sym_valid_d = 1'b0;
        end

        if (accept) begin
            if (bit_cnt_q == 2'd0) begin
                mode_d = bus.mode;
                if (bus.mode == 2'b11) mode_err_d = 1'b1;
            end
            if (final_bit) begin
                state_d     = COLLECT;
                bit_cnt_d   = 2'd0;
                sh_d        = 3'd0;
                sym_valid_d = 1'b1;
                case (eff_mode)
                    2'b00: begin
                        sym_i_d = axis_level(bits_full[0], 1'b0, 1'b0);
                        sym_q_d = '0;
                    end
                    2'b10: begin
                        sym_i_d = axis_level(bits_full[0], bits_full[1], 1'b1);
                        sym_q_d = axis_level(bits_full[2], bits_full[3], 1'b1);
                    end
                    default: begin
                        sym_i_d = axis_level(bits_full[0], 1'b0, 1'b0);
                        sym_q_d = axis_level(bits_full[1], 1'b0, 1'b0);
                    end
                endcase
            end else begin
                bit_cnt_d = bit_cnt_q + 2'd1;
                sh_d      = bits_full[2:0];
                state_d   = (bit_cnt_q + 2'd1 == last_idx) ? LAST : COLLECT;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q     <= COLLECT;
            bit_cnt_q   <= 2'd0;
            mode_q      <= 2'd0;
            sh_q        <= 3'd0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
            sym_count_q <= '0;
            mode_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            mode_q      <= mode_d;
            sh_q        <= sh_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_valid_q <= sym_valid_d;
            sym_count_q <= sym_count_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign bus.bit_ready = ready;
    assign bus.sym_i     = sym_i_q;
    assign bus.sym_q     = sym_q_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_count = sym_count_q;
    assign bus.mode_err  = mode_err_q;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Bench for qam_symbol_mapper: queue-based symbol model, per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic with backpressure and resets.
module tb_qam_symbol_mapper;
    localparam int OUT_W = 8;
    localparam int AMP   = 24;
    localparam int CNT_W = 4;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    qam_symbol_mapper_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();
    qam_symbol_mapper #(.OUT_W(OUT_W), .AMP(AMP), .CNT_W(CNT_W)) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        int i;
        int q;
    } sym_t;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    sym_t exp_q[$];
    sym_t got_q[$];
    int   bits_q[$];
    int   cur_mode = 0;
    int   mcount = 0;
    int   merr = 0;
    bit   model_rdy;
    int   gray_lut[4] = '{-3, -1, 3, 1};

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int kbits(input int m);
        if (m == 0) return 1;
        if (m == 2) return 4;
        return 2;
    endfunction

    function automatic bit model_ready();
        int m;
        bit fin;
        m   = (bits_q.size() == 0) ? int'(bus.mode) : cur_mode;
        fin = (bits_q.size() + 1 == kbits(m));
        return RESET_N && !(fin && exp_q.size() > 0 && !bus.sym_ready);
    endfunction

    function automatic sym_t map_bits();
        sym_t s;
        if (bits_q.size() == 1) begin
            s.i = bits_q[0] ? AMP : -AMP;
            s.q = 0;
        end else if (bits_q.size() == 2) begin
            s.i = bits_q[0] ? AMP : -AMP;
            s.q = bits_q[1] ? AMP : -AMP;
        end else begin
            s.i = gray_lut[bits_q[0] * 2 + bits_q[1]] * AMP;
            s.q = gray_lut[bits_q[2] * 2 + bits_q[3]] * AMP;
        end
        return s;
    endfunction

    // Reference model: advances on every rising edge from the inputs applied before it.
    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            exp_q.delete();
            bits_q.delete();
            mcount = 0;
            merr   = 0;
        end else begin
            model_rdy = model_ready();
            if (exp_q.size() > 0 && bus.sym_ready) begin
                void'(exp_q.pop_front());
                mcount = (mcount + 1) % (1 << CNT_W);
            end
            if (bus.bit_valid && model_rdy) begin
                if (bits_q.size() == 0) begin
                    cur_mode = int'(bus.mode);
                    if (cur_mode == 3) merr = 1;
                end
                bits_q.push_back(int'(bus.bit_in));
                if (bits_q.size() == kbits(cur_mode)) begin
                    exp_q.push_back(map_bits());
                    bits_q.delete();
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("sym_valid", bus.sym_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("sym_i", bus.sym_i, exp_q[0].i);
                chk("sym_q", bus.sym_q, exp_q[0].q);
            end
            chk("sym_count", bus.sym_count, mcount);
            chk("mode_err", bus.mode_err, merr);
            chk("bit_ready", bus.bit_ready, model_ready());
            if (bus.sym_valid && bus.sym_ready)
                got_q.push_back('{int'(bus.sym_i), int'(bus.sym_q)});
        end
    end

    task automatic send_bit(input int b, input int m);
        int n = 0;
        bit took = 1'b0;
        bus.bit_in    = 1'(b);
        bus.mode      = 2'(m);
        bus.bit_valid = 1'b1;
        while (!took && n < 40) begin
            @(negedge CLOCK_50);
            took = bus.bit_ready;
            @(posedge CLOCK_50);
            #2;
            n++;
        end
        bus.bit_valid = 1'b0;
        if (!took) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus.bit_valid = 1'b0;
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic check_got(input string name, input int idx, input int ei, input int eq);
        if (got_q.size() > idx) begin
            chk({name, "_i"}, got_q[idx].i, ei);
            chk({name, "_q"}, got_q[idx].q, eq);
        end else begin
            chk({name, "_missing"}, got_q.size(), idx + 1);
        end
    endtask

    initial begin
        bus.mode      = 2'd1;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.sym_ready = 1'b1;
        @(posedge CLOCK_50);
        #2;
        chk_en = 1'b1;
        @(posedge CLOCK_50);
        #2;
        chk("rst_valid", bus.sym_valid, 0);
        chk("rst_i", bus.sym_i, 0);
        chk("rst_q", bus.sym_q, 0);
        chk("rst_count", bus.sym_count, 0);
        chk("rst_err", bus.mode_err, 0);
        chk("rst_bit_ready", bus.bit_ready, 0);
        RESET_N = 1'b1;
        idle(1);

        // QPSK pair of symbols
        got_q.delete();
        send_bit(0, 1); send_bit(1, 1); send_bit(1, 1); send_bit(0, 1);
        idle(3);
        check_got("qpsk0", 0, -24, 24);
        check_got("qpsk1", 1, 24, -24);
        chk("qpsk_count", bus.sym_count, 2);

        // 16-QAM with output visible right after the last bit's edge
        got_q.delete();
        send_bit(1, 2); send_bit(0, 2); send_bit(0, 2); send_bit(1, 2);
        chk("qam_latency_valid", bus.sym_valid, 1);
        chk("qam_latency_i", bus.sym_i, 72);
        idle(3);
        check_got("qam", 0, 72, -24);

        // BPSK
        got_q.delete();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        idle(3);
        check_got("bpsk0", 0, 24, 0);
        check_got("bpsk1", 1, -24, 0);
        check_got("bpsk2", 2, 24, 0);

        // Downstream stall while the next symbol completes
        got_q.delete();
        bus.sym_ready = 1'b0;
        fork
            begin
                send_bit(1, 1); send_bit(1, 1); send_bit(0, 1); send_bit(0, 1);
            end
            begin
                repeat (6) @(posedge CLOCK_50);
                @(negedge CLOCK_50);
                chk("stall_bit_ready", bus.bit_ready, 0);
                chk("stall_i", bus.sym_i, 24);
                chk("stall_q", bus.sym_q, 24);
                @(posedge CLOCK_50);
                #2;
                bus.sym_ready = 1'b1;
            end
        join
        idle(3);
        check_got("stall0", 0, 24, 24);
        check_got("stall1", 1, -24, -24);
        chk("stall_no_dup", got_q.size(), 2);

        // Mode change after b0 is ignored until the next symbol
        got_q.delete();
        send_bit(1, 1); send_bit(0, 2);
        send_bit(1, 2); send_bit(1, 2); send_bit(0, 2); send_bit(0, 2);
        idle(3);
        check_got("modechg_qpsk", 0, 24, -24);
        check_got("modechg_qam", 1, 24, -72);

        // Reset in the middle of a 16-QAM symbol, then reserved mode
        send_bit(1, 2); send_bit(0, 2); send_bit(1, 2);
        RESET_N = 1'b0;
        @(posedge CLOCK_50);
        #2;
        chk("midrst_valid", bus.sym_valid, 0);
        chk("midrst_count", bus.sym_count, 0);
        chk("midrst_bit_ready", bus.bit_ready, 0);
        RESET_N = 1'b1;
        idle(1);
        got_q.delete();
        send_bit(0, 2); send_bit(0, 2); send_bit(1, 2); send_bit(1, 2);
        send_bit(1, 3); send_bit(0, 3);
        idle(3);
        check_got("fresh_qam", 0, -72, 24);
        check_got("reserved", 1, 24, -24);
        chk("reserved_err", bus.mode_err, 1);
        chk("fresh_count", bus.sym_count, 2);

        // Randomized traffic with backpressure, mode changes and rare resets
        for (int c = 0; c < 1500; c++) begin
            bus.bit_valid = ($urandom_range(0, 3) != 0);
            bus.bit_in    = 1'($urandom_range(0, 1));
            bus.mode      = 2'($urandom_range(0, 3));
            bus.sym_ready = ($urandom_range(0, 2) != 0);
            RESET_N       = ($urandom_range(0, 299) != 0);
            @(posedge CLOCK_50);
            #2;
        end
        RESET_N       = 1'b1;
        bus.sym_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
